// File: rtl/i2c_reg_seq.sv
// i2c_reg_seq: turns register read/write requests into I2C byte-engine sequences; define I2C_RETRY_EN to retry NACKed device addresses
module i2c_reg_seq #(
  parameter int DONE_TIMEOUT = 1024,
  parameter int TO_W = 11,
  parameter int RETRIES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_wr,
  input  logic [6:0] req_dev,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       rsp_timeout,
  output logic       byte_start,
  output logic [7:0] byte_data,
  output logic       byte_w_rn,
  output logic       byte_first,
  output logic       byte_last,
  output logic       byte_ack_out,
  input  logic [7:0] byte_rdata,
  input  logic       byte_ack_in,
  input  logic       byte_done
);
`ifdef I2C_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, ADDR_W, REG, WDATA, ADDR_R, RDATA, ABORT, RESP} state_t;
  state_t state, nxt;
  logic wr_q, nack_f, addr_nack, nack_now, retry, accept, expire, go;
  logic [6:0] dev_q, dev_s;
  logic [7:0] reg_q, wdata_q, n_data;
  logic [TO_W-1:0] cnt;
  logic [3:0] tries;
  logic n_first, n_last, n_wrn;
  always_comb begin
    accept = state == IDLE && req_valid && req_ready;
    expire = cnt == TO_W'(DONE_TIMEOUT - 1);
    nack_now = byte_ack_in && state != RDATA && state != ABORT;
    retry = RETRY_EN && addr_nack && tries < 4'(RETRIES);
    dev_s = state == IDLE ? req_dev : dev_q;
    nxt = RESP;
    case (state)
      IDLE:    nxt = ADDR_W;
      ADDR_W:  nxt = nack_now ? ABORT : REG;
      REG:     nxt = nack_now ? ABORT : (wr_q ? WDATA : ADDR_R);
      ADDR_R:  nxt = nack_now ? ABORT : RDATA;
      ABORT:   nxt = retry ? ADDR_W : RESP;
      default: nxt = RESP;
    endcase
    // read bytes and the STOP-only abort byte carry 0xFF on the data lines
    n_data = nxt == ADDR_W ? {dev_s, 1'b0} : nxt == REG ? reg_q : nxt == WDATA ? wdata_q :
             nxt == ADDR_R ? {dev_q, 1'b1} : 8'hFF;
    n_first = nxt == ADDR_W || nxt == ADDR_R;
    n_last = nxt == WDATA || nxt == RDATA || nxt == ABORT;
    n_wrn = nxt != RDATA;
    go = accept || (state != IDLE && state != RESP && byte_done && nxt != RESP);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_nack <= 1'b0;
      rsp_timeout <= 1'b0;
      byte_start <= 1'b0;
      byte_data <= '0;
      byte_w_rn <= 1'b1;
      byte_first <= 1'b0;
      byte_last <= 1'b0;
      byte_ack_out <= 1'b1;
      wr_q <= 1'b0;
      dev_q <= '0;
      reg_q <= '0;
      wdata_q <= '0;
      cnt <= '0;
      tries <= '0;
      nack_f <= 1'b0;
      addr_nack <= 1'b0;
    end else begin
      byte_start <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          wr_q <= req_wr;
          dev_q <= req_dev;
          reg_q <= req_reg;
          wdata_q <= req_wdata;
          req_ready <= 1'b0;
          tries <= '0;
          nack_f <= 1'b0;
          addr_nack <= 1'b0;
        end
        RESP: begin
          state <= IDLE;
          req_ready <= 1'b1;
        end
        default: if (byte_done) begin
          if (nack_now) begin
            nack_f <= 1'b1;
            addr_nack <= state == ADDR_W;
          end
          if (state == RDATA) rsp_rdata <= byte_rdata;
          if (state == ABORT && retry) begin
            tries <= tries + 1'b1;
            nack_f <= 1'b0;
            addr_nack <= 1'b0;
          end
          if (nxt == RESP) begin
            state <= RESP;
            rsp_valid <= 1'b1;
            rsp_nack <= nack_f | nack_now;
            rsp_timeout <= 1'b0;
          end
        end else if (expire) begin
          state <= RESP;
          rsp_valid <= 1'b1;
          rsp_nack <= nack_f;
          rsp_timeout <= 1'b1;
        end else cnt <= cnt + 1'b1;
      endcase
      if (go) begin
        state <= nxt;
        byte_start <= 1'b1;
        byte_data <= n_data;
        byte_first <= n_first;
        byte_last <= n_last;
        byte_w_rn <= n_wrn;
        cnt <= '0;
      end
    end
  end
endmodule
